// File: rtl/i2c_write_seq.sv
// i2c_write_seq: issues one I2C write transaction as a register-write program on the I2C core's mem bus.
// Define I2C_SEQ_POLL_EN to poll the core status register (0x1E) after each command instead of waiting CMD_WAIT cycles.
module i2c_write_seq #(
   parameter int unsigned BITRATE  = 500000,
   parameter int unsigned CMD_WAIT = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  req_addr,
   input  logic [3:0]  req_len,
   input  logic        data_valid,
   input  logic [7:0]  data_byte,
   output logic        data_ready,
   output logic        busy,
   output logic        done,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [3:0] {
      IDLE, CFG, ADDR, START, WAIT, FETCH, DATA, SEND, STOP, DONE
   } state_t;

   state_t      state, state_d, wait_exit, cmd_next;
   logic        cfg_done, cfg_done_d;
   logic        stop_sent, stop_sent_d;
   logic        gap;
   logic [6:0]  addr_q, addr_d;
   logic [3:0]  remaining, remaining_d;
   logic [7:0]  byte_q, byte_d;
   logic        rdata_unused;
`ifndef I2C_SEQ_POLL_EN
   logic [31:0] wait_cnt, wait_cnt_d;
`endif

   assign rdata_unused = ^mem_rdata;

   // gap forces one idle bus cycle after every completed access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cfg_done  <= 1'b0;
         stop_sent <= 1'b0;
         gap       <= 1'b0;
         addr_q    <= '0;
         remaining <= '0;
         byte_q    <= '0;
`ifndef I2C_SEQ_POLL_EN
         wait_cnt  <= '0;
`endif
      end else begin
         state     <= state_d;
         cfg_done  <= cfg_done_d;
         stop_sent <= stop_sent_d;
         gap       <= mem_valid & mem_ready;
         addr_q    <= addr_d;
         remaining <= remaining_d;
         byte_q    <= byte_d;
`ifndef I2C_SEQ_POLL_EN
         wait_cnt  <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state;
      cfg_done_d  = cfg_done;
      stop_sent_d = stop_sent;
      addr_d      = addr_q;
      remaining_d = remaining;
      byte_d      = byte_q;
`ifndef I2C_SEQ_POLL_EN
      wait_cnt_d  = wait_cnt;
`endif
      req_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      data_ready  = 1'b0;
      mem_valid   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wstrb   = '0;

      wait_exit = (remaining != '0) ? FETCH : ((stop_sent || state == STOP) ? DONE : STOP);
`ifdef I2C_SEQ_POLL_EN
      cmd_next  = WAIT;
`else
      // a zero-length wait bypasses WAIT entirely
      cmd_next  = (CMD_WAIT == 0) ? wait_exit : WAIT;
`endif

      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               addr_d      = req_addr;
               remaining_d = req_len;
               stop_sent_d = 1'b0;
               state_d     = cfg_done ? ADDR : CFG;
            end
         end
         CFG: begin
            mem_valid = !gap;
            mem_addr  = 32'h1C;
            mem_wdata = BITRATE;
            mem_wstrb = '1;
            if (!gap && mem_ready) begin
               cfg_done_d = 1'b1;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            mem_valid = !gap;
            mem_addr  = 32'h1D;
            mem_wdata = {24'h0, addr_q, 1'b0};
            mem_wstrb = '1;
            if (!gap && mem_ready) state_d = START;
         end
         START, SEND, STOP: begin
            mem_valid = !gap;
            mem_addr  = 32'h1F;
            mem_wdata = (state == START) ? 32'h50 : ((state == SEND) ? 32'h48 : 32'h20);
            mem_wstrb = '1;
            if (!gap && mem_ready) begin
               if (state == STOP) stop_sent_d = 1'b1;
               state_d = cmd_next;
`ifndef I2C_SEQ_POLL_EN
               wait_cnt_d = CMD_WAIT - 1;
`endif
            end
         end
         WAIT: begin
`ifdef I2C_SEQ_POLL_EN
            mem_valid = !gap;
            mem_addr  = 32'h1E;
            if (!gap && mem_ready && !mem_rdata[0]) state_d = wait_exit;
`else
            if (wait_cnt == '0) state_d = wait_exit;
            else                wait_cnt_d = wait_cnt - 1;
`endif
         end
         FETCH: begin
            data_ready = 1'b1;
            if (data_valid) begin
               byte_d      = data_byte;
               remaining_d = remaining - 4'd1;
               state_d     = DATA;
            end
         end
         DATA: begin
            mem_valid = !gap;
            mem_addr  = 32'h1D;
            mem_wdata = {24'h0, byte_q};
            mem_wstrb = '1;
            if (!gap && mem_ready) state_d = SEND;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_write_seq.sv
// Scoreboard bench for i2c_write_seq: expected bus accesses are queued as requests are driven
// and matched against each completed access by a small I2C-core responder model.
`timescale 1ns/1ps
module tb_i2c_write_seq;
   localparam int unsigned BITRATE  = 500000;
   localparam int unsigned CMD_WAIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [6:0]  req_addr;
   logic [3:0]  req_len;
   logic        data_valid, data_ready;
   logic [7:0]  data_byte;
   logic        busy, done;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   i2c_write_seq #(.BITRATE(BITRATE), .CMD_WAIT(CMD_WAIT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .data_valid(data_valid), .data_byte(data_byte), .data_ready(data_ready),
      .busy(busy), .done(done),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } acc_t;

   acc_t        exp_q[$];
   logic [7:0]  pay [16];
   int unsigned vectors = 0, miscompares = 0;
   int unsigned done_cnt = 0, dr_cnt = 0, cyc = 0, stop_ack_cyc = 0, done_cyc = 0, done_base = 0;
   int unsigned busy_left;
   logic        cfg_model = 1'b0;
   logic        hold_send = 1'b0;

   task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // I2C core: acks one cycle after mem_valid appears; status busy for 3 polls after each command
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         busy_left <= 0;
      end else begin
         mem_ready <= 1'b0;
         if (mem_valid && !mem_ready && !(hold_send && mem_addr == 32'h1F && mem_wdata == 32'h48)) begin
            mem_ready <= 1'b1;
            if (mem_wstrb == 4'h0) begin
               mem_rdata <= {31'h0, busy_left != 0};
               if (busy_left != 0) busy_left <= busy_left - 1;
            end else if (mem_addr == 32'h1F) begin
               busy_left <= 3;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         acc_t e;
         cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (data_ready) dr_cnt++;
         if (mem_valid && mem_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("bus_access", {mem_addr, mem_wdata, mem_wstrb}, e);
            if (mem_addr == 32'h1F && mem_wdata == 32'h20) stop_ack_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [7:0] c);
      exp_q.push_back({32'h1F, 32'(c), 4'hF});
`ifdef I2C_SEQ_POLL_EN
      for (int i = 0; i < 4; i++) exp_q.push_back({32'h1E, 32'h0, 4'h0});
`endif
   endtask

   task automatic push_expect(input logic [6:0] a, input logic [3:0] n);
      if (!cfg_model) begin
         exp_q.push_back({32'h1C, 32'(BITRATE), 4'hF});
         cfg_model = 1'b1;
      end
      exp_q.push_back({32'h1D, 32'({a, 1'b0}), 4'hF});
      push_cmd(8'h50);
      for (int unsigned i = 0; i < n; i++) begin
         exp_q.push_back({32'h1D, 32'(pay[i]), 4'hF});
         push_cmd(8'h48);
      end
      push_cmd(8'h20);
      done_base = done_cnt;
      req_addr  = a;
      req_len   = n;
   endtask

   task automatic request(input logic [6:0] a, input logic [3:0] n);
      check("req_ready_idle", req_ready, 1'b1);
      push_expect(a, n);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic feed(input logic [7:0] b, input int unsigned stall);
      int unsigned n = 0;
      while (data_ready !== 1'b1 && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) check("fetch_timeout", data_ready, 1'b1);
      repeat (stall) step();
      if (stall != 0) begin
         check("stall_data_ready", data_ready, 1'b1);
         check("stall_mem_valid", mem_valid, 1'b0);
         check("stall_busy", busy, 1'b1);
      end
      data_byte  = b;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      data_byte  = '0;
   endtask

   // Waits for done; optionally raises the next request during the done cycle.
   task automatic finish_txn(input logic chain, input logic [6:0] a, input logic [3:0] n);
      int unsigned k = 0;
      while (done !== 1'b1 && k < 2000) begin
         step();
         k++;
      end
      check("done_seen", done, 1'b1);
      check("req_ready_in_done", req_ready, 1'b0);
      check("sb_drained", 68'(exp_q.size()), 68'(0));
      if (chain) begin
         push_expect(a, n);
         req_valid = 1'b1;
      end
      step();
      check("req_ready_after_done", req_ready, 1'b1);
      check("done_one_cycle", done, 1'b0);
      check("no_accept_in_done", mem_valid, 1'b0);
      check("done_pulses", 68'(done_cnt - done_base), 68'(1));
`ifndef I2C_SEQ_POLL_EN
      check("stop_to_done", 68'(done_cyc - stop_ack_cyc), 68'(CMD_WAIT + 1));
`endif
      if (chain) begin
         done_base = done_cnt;
         step();
         req_valid = 1'b0;
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      step();
      exp_q.delete();
      cfg_model = 1'b0;
      rst = 1'b0;
      step();
   endtask

   initial begin
      int unsigned n;
      int unsigned dr0;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
      data_valid = 1'b0; data_byte = '0;
      repeat (3) step();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_data_ready", data_ready, 1'b0);
      check("rst_mem", {mem_valid, mem_addr, mem_wdata, mem_wstrb}, '0);
      rst = 1'b0;
      step();

      // one byte, first transaction writes bitrate
      pay[0] = 8'h55;
      request(7'h55, 4'd1);
      feed(8'h55, 0);
      finish_txn(1'b0, '0, '0);

      // same request again: bitrate skipped; next request raised during done
      request(7'h55, 4'd1);
      feed(8'h55, 0);
      pay[0] = 8'hA5; pay[1] = 8'h3C;
      finish_txn(1'b1, 7'h2A, 4'd2);
      feed(8'hA5, 0);
      feed(8'h3C, 0);
      finish_txn(1'b0, '0, '0);

      // address-only after reset
      rst_pulse();
      dr0 = dr_cnt;
      request(7'h10, 4'd0);
      finish_txn(1'b0, '0, '0);
      check("len0_no_data_ready", 68'(dr_cnt - dr0), 68'(0));

      // three bytes with a 20-cycle stall before byte 2
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      request(7'h3A, 4'd3);
      feed(8'h11, 0);
      feed(8'h22, 20);
      feed(8'h33, 0);
      finish_txn(1'b0, '0, '0);

      // reset while the SEND write is stalled
      hold_send = 1'b1;
      pay[0] = 8'h77;
      request(7'h33, 4'd1);
      feed(8'h77, 0);
      n = 0;
      while (!(mem_valid === 1'b1 && mem_addr === 32'h1F && mem_wdata === 32'h48) && n < 500) begin
         step();
         n++;
      end
      repeat (3) step();
      check("send_held", {mem_valid, mem_addr, mem_wdata}, {1'b1, 32'h1F, 32'h48});
      #2 rst = 1'b1;
      #1;
      check("async_rst_mem", {mem_valid, mem_addr, mem_wdata, mem_wstrb}, '0);
      check("async_rst_req_ready", req_ready, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      exp_q.delete();
      cfg_model = 1'b0;
      hold_send = 1'b0;
      step();
      rst = 1'b0;
      step();

      // first request after reset rewrites bitrate
      pay[0] = 8'h55;
      request(7'h55, 4'd1);
      feed(8'h55, 0);
      finish_txn(1'b0, '0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/i2c_write_seq.md
# i2c_write_seq

Transaction sequencer for the memory-mapped I2C master core. It takes a single write request (7-bit slave address plus 0–15 payload bytes) and issues the core's register-write program through the core's mem bus in order: bitrate, address byte, START, one data/send pair per byte, then STOP. It sits between user logic and the I2C core, replacing hand-sequenced firmware writes.

## Interface
- BITRATE, 500000: value written to the bitrate register (0x1C).
- CMD_WAIT, 10: idle cycles after each command-register write completes, used when polling is compiled out; 0 is legal.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  7  slave address.
- req_len  in  4  payload byte count, 0..15.
- data_valid  in  1  payload byte available.
- data_byte  in  8  payload byte.
- data_ready  out  1  byte accepted when data_valid & data_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at transaction end.
- mem_valid  out  1  bus request to the I2C core.
- mem_addr  out  32  core register address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_rdata  in  32  core read data.
- mem_ready  in  1  core acknowledge.

## Operation
- Bus access rules:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled high.
  - mem_valid drops in the following cycle, so there is at least one idle cycle between accesses.
  - mem_wdata upper bits are zero unless stated otherwise.
- States:
  - IDLE: go to CFG on req_valid.
  - CFG: write 0x1C = BITRATE. This happens only when cfg_done is clear, then cfg_done is set. Otherwise CFG is skipped and the block goes straight to ADDR.
  - ADDR: write 0x1D = {req_addr, 1'b0}.
  - START: write 0x1F = 8'h50.
  - WAIT: wait for the command to complete.
  - FETCH: data_ready is high; wait for data_valid.
  - DATA: write 0x1D = captured byte.
  - SEND: write 0x1F = 8'h48, then WAIT.
  - STOP: write 0x1F = 8'h20, then WAIT.
  - DONE: pulse done for one cycle, return to IDLE.
- After WAIT:
  - If remaining > 0, go to FETCH.
  - If remaining = 0 and the STOP command has not yet been sent, go to STOP.
  - If the wait followed STOP, go to DONE.
- req_addr and req_len are captured on acceptance. The remaining counter starts at req_len and decrements once per byte accepted in FETCH.
- req_len = 0 produces an address-only transaction: START, then STOP, with no FETCH.
- data_valid is ignored outside FETCH. The payload source may stall indefinitely; the block waits in FETCH with no timeout.
- If mem_ready never arrives, the block stays in the current state until reset. This is intentional; there is no bus timeout.

## Timing
- Reset values:
  - All outputs are 0, except req_ready = 1.
  - State = IDLE, cfg_done = 0, remaining = 0.
- Reset mid-transaction:
  - All outputs clear asynchronously and the current access is abandoned.
  - cfg_done clears, so the next transaction rewrites bitrate.
- Request acceptance:
  - A request is accepted on the edge where req_valid & req_ready.
  - mem_valid for the first access is asserted the next cycle.
- Without polling, WAIT lasts exactly CMD_WAIT cycles after the mem_ready cycle of the command write.
- done asserts in the cycle after WAIT ends following STOP.
- req_ready returns high the cycle after done.
- A req_valid present in the done cycle is not accepted until IDLE.

## Configuration
- I2C_SEQ_POLL_EN defined:
  - WAIT polls the status register instead of counting.
  - Each poll is a read of 0x1E (mem_wstrb = 0).
  - If mem_rdata[0] (core busy) = 1, the read repeats after one idle cycle.
  - If mem_rdata[0] = 0, WAIT exits and CMD_WAIT is unused.
- I2C_SEQ_POLL_EN undefined:
  - WAIT uses the fixed CMD_WAIT counter.
  - mem_rdata is ignored and no reads are ever issued.

## Test plan
- Reset, then req_addr=7'h55, req_len=1, byte 8'h55; core mem_ready after 1 cycle:
  - Writes occur in order (0x1C,500000), (0x1D,0xAA), (0x1F,0x50), (0x1D,0x55), (0x1F,0x48), (0x1F,0x20).
  - One done pulse is produced.
- A second identical request without reset:
  - No 0x1C write.
  - The first access is (0x1D,0xAA).
- req_len=0, req_addr=7'h10:
  - Writes are (0x1C), (0x1D,0x20), (0x1F,0x50), (0x1F,0x20).
  - data_ready is never asserted.
- req_len=3, with data_valid withheld 20 cycles before byte 2:
  - The block stays in FETCH with data_ready=1 and mem_valid=0.
  - The three bytes go out in order.
- Assert rst during the SEND write with mem_ready held low:
  - Outputs read 0 and req_ready=1 in the same cycle.
  - The next request starts with the 0x1C write.
- I2C_SEQ_POLL_EN with the model returning busy=1 for 3 reads, then 0:
  - Exactly 4 reads of 0x1E follow each command write before the next access.
